// File: rtl/rr_arbiter_eight_pkg.sv
// rtl/rr_arbiter_eight_pkg.sv - shared constants and state encoding for the eight-way arbiter
//
// Purpose : state encoding and sizing constants used by rr_arbiter_eight.
// Contents: N_REQ, IDX_W, state_t (ST_IDLE, ST_GRANT, ST_RELEASE).

package rr_arbiter_eight_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter_eight_decode.sv
// rtl/rr_arbiter_eight_decode.sv - 3-to-8 enabled decoder driving the one-hot grant
//
// Purpose : decode a 3-bit index into a one-hot vector, all zero when disabled.
// Ports   : iEnable  in  1  decoder enable
//           iData    in  3  index to decode
//           oDecode  out 8  one-hot result, zero when iEnable=0

module decodeThreeoEight (
  input  logic       iEnable,
  input  logic [2:0] iData,
  output logic [7:0] oDecode
);

  always_comb begin
    oDecode = '0;
    if (iEnable) begin
      oDecode[iData] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_eight.sv
// rtl/rr_arbiter_eight.sv - eight-way round-robin arbiter with hold-time limit
//
// Purpose : share one resource between eight requesters in round-robin order.
//           A grant lasts until the owner pulses iDone, drops its request, or
//           has held the grant for MAX_HOLD cycles (MAX_HOLD=0 disables the limit).
// Ports   : iClk       in   1  system clock, rising edge
//           iRst_n     in   1  synchronous reset, active-low
//           iReq       in   8  level-sensitive request lines
//           iDone      in   1  release strobe from the current owner
//           oGrant     out  8  one-hot grant, zero when no owner
//           oGrantIdx  out  3  index of the current owner (valid with oValid)
//           oValid     out  1  a grant is active
//           oTimeout   out  1  one-cycle pulse when a grant was revoked by the limit

module rr_arbiter_eight
  import rr_arbiter_eight_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [N_REQ-1:0] iReq,
  input  logic             iDone,
  output logic [N_REQ-1:0] oGrant,
  output logic [IDX_W-1:0] oGrantIdx,
  output logic             oValid,
  output logic             oTimeout
);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last_idx;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_timeout;

  logic [IDX_W-1:0]   w_pick;
  logic               w_owner_quit;
  logic               w_limit;

  // Owner gives up the grant voluntarily; this wins over the hold limit
  // when both happen in the same cycle, so no timeout is reported then.
  assign w_owner_quit = iDone | ~iReq[r_idx];
  assign w_limit      = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD - 1));

  // Round-robin search starting just above the last owner. Walking the
  // offsets from farthest to nearest lets the nearest set request win;
  // offset N_REQ wraps to the last owner itself, which therefore ranks lowest.
  always_comb begin
    w_pick = r_last_idx;
    for (int k = N_REQ; k >= 1; k--) begin
      if (iReq[r_last_idx + IDX_W'(k)]) begin
        w_pick = r_last_idx + IDX_W'(k);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|iReq) begin
          w_next_state = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_owner_quit || w_limit) begin
          w_next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_last_idx <= IDX_W'(N_REQ - 1);
      r_hold     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|iReq) begin
            r_idx  <= w_pick;
            r_hold <= '0;
          end
        end
        ST_GRANT: begin
          r_hold <= r_hold + HOLD_W'(1);
          if (!w_owner_quit && w_limit) begin
            r_timeout <= 1'b1;
          end
        end
        ST_RELEASE: r_last_idx <= r_idx;
        default: ;
      endcase
    end
  end

  assign oValid    = (r_state == ST_GRANT);
  assign oGrantIdx = r_idx;
  assign oTimeout  = r_timeout;

  decodeThreeoEight u_decode (
    .iEnable (oValid),
    .iData   (r_idx),
    .oDecode (oGrant)
  );

endmodule

// File: tb/tb_rr_arbiter_eight.sv
// tb/tb_rr_arbiter_eight.sv - self-checking bench for rr_arbiter_eight

module tb_rr_arbiter_eight;

  localparam int MAX_HOLD = 16;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [7:0] iReq = 8'h00;
  logic       iDone = 1'b0;
  logic [7:0] oGrant;
  logic [2:0] oGrantIdx;
  logic       oValid;
  logic       oTimeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter_eight #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iReq      (iReq),
    .iDone     (iDone),
    .oGrant    (oGrant),
    .oGrantIdx (oGrantIdx),
    .oValid    (oValid),
    .oTimeout  (oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the resource, how long it has owned it,
  // whether we are in the gap after a release, and whose turn it is next.
  int   m_owner = -1;
  int   m_held = 0;
  int   m_gap = 0;
  int   m_gap_owner = 0;
  int   m_last = 7;
  int   m_idx = 0;
  logic m_to = 1'b0;

  initial begin
    logic       s_rst;
    logic [7:0] s_req;
    logic       s_done;
    logic       quit;
    logic       lim;
    logic [7:0] e_grant;
    forever begin
      @(posedge iClk);
      s_rst  = iRst_n;
      s_req  = iReq;
      s_done = iDone;
      if (!s_rst) begin
        m_owner = -1; m_held = 0; m_gap = 0; m_last = 7; m_idx = 0; m_to = 1'b0;
      end else if (m_owner >= 0) begin
        m_held++;
        m_to = 1'b0;
        quit = s_done || !s_req[m_owner];
        lim  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
        if (quit || lim) begin
          m_to        = !quit;
          m_gap_owner = m_owner;
          m_owner     = -1;
          m_gap       = 1;
        end
      end else if (m_gap != 0) begin
        m_gap  = 0;
        m_last = m_gap_owner;
        m_to   = 1'b0;
      end else begin
        m_to = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          if (m_owner < 0 && s_req[(m_last + k) % 8]) begin
            m_owner = (m_last + k) % 8;
            m_idx   = m_owner;
            m_held  = 0;
          end
        end
      end
      #1;
      e_grant = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      chk("model_grant", oGrant, e_grant);
      chk("model_valid", oValid, m_owner >= 0);
      chk("model_timeout", oTimeout, m_to);
      if (m_owner >= 0) chk("model_idx", oGrantIdx, m_idx);
      chk("onehot0", $onehot0(oGrant), 1);
      chk("valid_vs_grant", oValid, |oGrant);
      if (oValid) chk("grant_vs_idx", oGrant, 8'h01 << oGrantIdx);
    end
  end

  task automatic clk1();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    int cnt;
    logic [7:0] exp_g;

    // 1: reset, then two requesters; 0 wins first, 7 next
    clk1(); clk1();
    chk("rst_grant", oGrant, 8'h00);
    chk("rst_valid", oValid, 0);
    chk("rst_idx", oGrantIdx, 0);
    chk("rst_timeout", oTimeout, 0);
    iRst_n = 1'b1; iReq = 8'h81;
    clk1();
    chk("t1_grant0", oGrant, 8'h01);
    chk("t1_idx0", oGrantIdx, 0);
    iDone = 1'b1;
    clk1();
    iDone = 1'b0;
    chk("t1_release", oGrant, 8'h00);
    clk1();
    chk("t1_idle", oGrant, 8'h00);
    clk1();
    chk("t1_grant7", oGrant, 8'h80);
    chk("t1_idx7", oGrantIdx, 7);
    iReq = 8'h00;
    clk1(); clk1();

    // 2: everyone requesting, each owner releases after 3 cycles
    iReq = 8'hFF;
    clk1();
    for (int g = 0; g < 9; g++) begin
      exp_g = 8'h01 << (g % 8);
      chk("t2_c1", oGrant, exp_g);
      clk1();
      chk("t2_c2", oGrant, exp_g);
      clk1();
      chk("t2_c3", oGrant, exp_g);
      iDone = 1'b1;
      clk1();
      iDone = 1'b0;
      chk("t2_gap_rel", oGrant, 8'h00);
      if (g == 8) iReq = 8'h00;
      clk1();
      chk("t2_gap_idle", oGrant, 8'h00);
      clk1();
    end

    // 3: single requester never releases; hold limit revokes it
    iReq = 8'h04;
    clk1();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (oGrant != 8'h04) break;
      cnt++;
      clk1();
    end
    chk("t3_hold_cycles", cnt, 16);
    chk("t3_timeout", oTimeout, 1);
    clk1();
    chk("t3_timeout_end", oTimeout, 0);
    clk1();
    chk("t3_regrant", oGrant, 8'h04);

    // 4: owner 2 drops its request while 5 waits
    iReq = 8'h24;
    clk1(); clk1(); clk1();
    chk("t4_still2", oGrant, 8'h04);
    iReq = 8'h20;
    clk1();
    chk("t4_rel", oGrant, 8'h00);
    chk("t4_no_to", oTimeout, 0);
    clk1();
    clk1();
    chk("t4_grant5", oGrant, 8'h20);
    iReq = 8'h00;
    clk1(); clk1();

    // 5: iDone coincides with the hold limit; iDone in IDLE is ignored
    iReq = 8'h08;
    clk1();
    chk("t5_grant3", oGrant, 8'h08);
    repeat (15) clk1();
    chk("t5_cycle16", oGrant, 8'h08);
    iDone = 1'b1;
    clk1();
    iDone = 1'b0;
    chk("t5_rel", oGrant, 8'h00);
    chk("t5_no_to", oTimeout, 0);
    iReq = 8'h00;
    clk1();
    iDone = 1'b1;
    clk1();
    iDone = 1'b0;
    chk("t5_idle_done_v", oValid, 0);
    chk("t5_idle_done_t", oTimeout, 0);
    clk1();
    chk("t5_idle_still", oGrant, 8'h00);

    // 6: reset in the middle of a grant to 6, then 0 wins after reset
    iReq = 8'h40;
    clk1();
    chk("t6_grant6", oGrant, 8'h40);
    chk("t6_idx6", oGrantIdx, 6);
    clk1();
    iRst_n = 1'b0;
    clk1();
    chk("t6_rst_grant", oGrant, 8'h00);
    chk("t6_rst_valid", oValid, 0);
    chk("t6_rst_idx", oGrantIdx, 0);
    chk("t6_rst_to", oTimeout, 0);
    iRst_n = 1'b1; iReq = 8'hC1;
    clk1();
    chk("t6_grant0", oGrant, 8'h01);
    chk("t6_idx0", oGrantIdx, 0);
    iReq = 8'h00;
    clk1(); clk1(); clk1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
